// File: rtl/global_defs.sv
// Shared types for the trace request queue: opcodes, FSM states
// and the stored request record.
package global_defs;

    localparam int ADDRESS_WIDTH = 33;
    localparam int TIME_WIDTH    = 64;

    typedef enum logic [1:0] {
        NOP   = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FENCE = 2'd3
    } parsed_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } queue_states_t;

    // "time" is a reserved word, so the release cycle field is timestamp
    typedef struct packed {
        logic [TIME_WIDTH-1:0]    timestamp;
        parsed_op_t               op;
        logic [ADDRESS_WIDTH-1:0] address;
    } trace_req_t;

endpackage

// File: rtl/req_fifo.sv
// Circular buffer holding queued trace requests; head is read
// combinationally from the read pointer, count separates full from empty.
module req_fifo #(
    parameter int  DEPTH   = 16,
    parameter type entry_t = logic [7:0]
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  entry_t                     wdata,
    output entry_t                     head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/trace_request_queue.sv
// Timestamped request queue: releases the head once the simulated cycle
// reaches its release time, optionally skipping idle cycles.
module trace_request_queue
    import global_defs::*;
#(
    parameter int ADDRESS_WIDTH = global_defs::ADDRESS_WIDTH,
    parameter int TIME_WIDTH    = 64,
    parameter int DEPTH         = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       skip_idle,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TIME_WIDTH-1:0]      in_time,
    input  parsed_op_t                 in_op,
    input  logic [ADDRESS_WIDTH-1:0]   in_address,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TIME_WIDTH-1:0]      out_time,
    output parsed_op_t                 out_op,
    output logic [ADDRESS_WIDTH-1:0]   out_address,
    output logic [TIME_WIDTH-1:0]      cycle,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err_order,
    output queue_states_t              state
);

    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [TIME_WIDTH-1:0]    timestamp;
        parsed_op_t               op;
        logic [ADDRESS_WIDTH-1:0] address;
    } entry_t;

    entry_t                wdata;
    entry_t                head;
    entry_t                last_pop;
    entry_t                shown;
    logic                  push;
    logic                  store;
    logic                  pop;
    logic                  nonempty;
    logic                  due;
    logic                  jump;
    logic [TIME_WIDTH-1:0] cycle_inc;
    logic [TIME_WIDTH-1:0] last_time;
    queue_states_t         state_next;

    assign wdata    = '{timestamp: in_time, op: in_op, address: in_address};
    assign nonempty = (count != '0);
    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign store    = push && (in_op != NOP);
    assign due      = nonempty && (cycle >= head.timestamp);
    assign out_valid = due;
    assign pop      = due && out_ready;

    // NOP requests are handshaken but never enter storage
    req_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (store),
        .pop   (pop),
        .wdata (wdata),
        .head  (head),
        .count (count)
    );

    // An empty queue keeps presenting the most recently popped request
    assign shown       = nonempty ? head : last_pop;
    assign out_time    = shown.timestamp;
    assign out_op      = shown.op;
    assign out_address = shown.address;

    assign cycle_inc = (&cycle) ? cycle : cycle + TIME_WIDTH'(1);
    assign jump      = skip_idle && (state == WAIT) && nonempty
                       && (head.timestamp > cycle_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle     <= '0;
            last_pop  <= '{timestamp: '0, op: NOP, address: '0};
            last_time <= '0;
            err_order <= 1'b0;
        end else begin
            cycle <= jump ? head.timestamp : cycle_inc;
            if (pop) begin
                last_pop <= head;
            end
            if (store) begin
                last_time <= in_time;
                if (in_time < last_time) begin
                    err_order <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (nonempty) begin
                    state_next = due ? ISSUE : WAIT;
                end
            end
            WAIT: begin
                if (!nonempty) begin
                    state_next = IDLE;
                end else if (due) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!nonempty) begin
                    state_next = IDLE;
                end else if (!due) begin
                    state_next = WAIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_trace_request_queue.sv
// Directed bench for trace_request_queue: a vector table for the basic
// release flow plus hand sequences for the multi-cycle corner cases.
module tb_trace_request_queue;
    import global_defs::*;

    localparam int AW = 33;
    localparam int TW = 64;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH+1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            skip_idle = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [TW-1:0]   in_time = '0;
    parsed_op_t      in_op = NOP;
    logic [AW-1:0]   in_address = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [TW-1:0]   out_time;
    parsed_op_t      out_op;
    logic [AW-1:0]   out_address;
    logic [TW-1:0]   cycle;
    logic [CW-1:0]   count;
    logic            err_order;
    queue_states_t   state;

    int checks = 0;
    int errors = 0;

    trace_request_queue #(
        .ADDRESS_WIDTH (AW),
        .TIME_WIDTH    (TW),
        .DEPTH         (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .skip_idle   (skip_idle),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_time     (in_time),
        .in_op       (in_op),
        .in_address  (in_address),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_time    (out_time),
        .out_op      (out_op),
        .out_address (out_address),
        .cycle       (cycle),
        .count       (count),
        .err_order   (err_order),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        parsed_op_t    op;
        logic [TW-1:0] t;
        logic [AW-1:0] a;
        logic          rdy;
        int            e_cnt;
        logic          e_ov;
        logic [TW-1:0] e_cyc;
        logic [AW-1:0] e_addr;
        queue_states_t e_st;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input parsed_op_t op,
                         input logic [TW-1:0] t, input logic [AW-1:0] a);
        in_valid   = v;
        in_op      = op;
        in_time    = t;
        in_address = a;
    endtask

    task automatic do_reset();
        drive(1'b0, NOP, '0, '0);
        out_ready = 1'b0;
        skip_idle = 1'b0;
        rst = 1'b1;
        edge_step();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, NOP,   64'd0, 33'h0,    1'b1, 0, 1'b0, 64'd1,  33'h0,    IDLE};
        vecs[1]  = '{1'b1, READ,  64'd5, 33'h1A2B, 1'b1, 1, 1'b0, 64'd2,  33'h1A2B, IDLE};
        vecs[2]  = '{1'b0, NOP,   64'd0, 33'h0,    1'b1, 1, 1'b0, 64'd3,  33'h1A2B, WAIT};
        vecs[3]  = '{1'b0, NOP,   64'd0, 33'h0,    1'b1, 1, 1'b0, 64'd4,  33'h1A2B, WAIT};
        vecs[4]  = '{1'b0, NOP,   64'd0, 33'h0,    1'b1, 1, 1'b1, 64'd5,  33'h1A2B, WAIT};
        vecs[5]  = '{1'b0, NOP,   64'd0, 33'h0,    1'b1, 0, 1'b0, 64'd6,  33'h1A2B, ISSUE};
        vecs[6]  = '{1'b0, NOP,   64'd0, 33'h0,    1'b1, 0, 1'b0, 64'd7,  33'h1A2B, IDLE};
        vecs[7]  = '{1'b1, NOP,   64'd3, 33'h55,   1'b1, 0, 1'b0, 64'd8,  33'h1A2B, IDLE};
        vecs[8]  = '{1'b1, WRITE, 64'd8, 33'h77,   1'b0, 1, 1'b1, 64'd9,  33'h77,   IDLE};
        vecs[9]  = '{1'b0, NOP,   64'd0, 33'h0,    1'b0, 1, 1'b1, 64'd10, 33'h77,   ISSUE};
        vecs[10] = '{1'b0, NOP,   64'd0, 33'h0,    1'b1, 0, 1'b0, 64'd11, 33'h77,   ISSUE};
        vecs[11] = '{1'b0, NOP,   64'd0, 33'h0,    1'b1, 0, 1'b0, 64'd12, 33'h77,   IDLE};

        // reset values while rst is held
        edge_step();
        chk("rst_cycle", cycle, 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_state", 64'(state), 64'(IDLE));
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_out_time", out_time, 0);
        chk("rst_out_op", 64'(out_op), 64'(NOP));
        chk("rst_out_address", 64'(out_address), 0);
        chk("rst_err_order", 64'(err_order), 0);
        rst = 1'b0;

        // basic release flow
        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].t, vecs[i].a);
            out_ready = vecs[i].rdy;
            edge_step();
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("vec%0d_cycle", i), cycle, vecs[i].e_cyc);
            chk($sformatf("vec%0d_out_address", i), 64'(out_address), 64'(vecs[i].e_addr));
            chk($sformatf("vec%0d_state", i), 64'(state), 64'(vecs[i].e_st));
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 1);
            chk($sformatf("vec%0d_err_order", i), 64'(err_order), 0);
        end

        // fast-forward over idle cycles
        do_reset();
        skip_idle = 1'b1;
        drive(1'b1, WRITE, 64'd1000, 33'h3FF);
        edge_step();
        drive(1'b0, NOP, '0, '0);
        begin
            bit reached = 1'b0;
            for (int k = 0; k < 3 && !reached; k++) begin
                if (cycle == 64'd1000) reached = 1'b1;
                else edge_step();
            end
            if (cycle == 64'd1000) reached = 1'b1;
            chk("ff_cycle_reached", 64'(reached), 1);
        end
        chk("ff_cycle", cycle, 64'd1000);
        chk("ff_out_valid", 64'(out_valid), 1);
        chk("ff_out_address", 64'(out_address), 64'h3FF);
        chk("ff_out_op", 64'(out_op), 64'(WRITE));
        skip_idle = 1'b0;
        out_ready = 1'b1;
        edge_step();
        chk("ff_drained", 64'(count), 0);

        // full queue with DEPTH=4, then drain in order
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, READ, 64'(i), 33'(33'h100 + i));
            edge_step();
        end
        chk("full_count", 64'(count), 4);
        chk("full_in_ready", 64'(in_ready), 0);
        drive(1'b1, READ, 64'd4, 33'h104);
        edge_step();
        chk("full_ignored_count", 64'(count), 4);
        drive(1'b0, NOP, '0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_valid", i), 64'(out_valid), 1);
            chk($sformatf("drain%0d_address", i), 64'(out_address), 64'(33'h100 + i));
            edge_step();
        end
        chk("drain_count", 64'(count), 0);
        chk("drain_out_valid", 64'(out_valid), 0);
        chk("drain_hold_address", 64'(out_address), 64'h103);

        // simultaneous push and pop at count 1
        do_reset();
        drive(1'b1, READ, 64'd0, 33'hA);
        edge_step();
        chk("pp_head_a", 64'(out_address), 64'hA);
        chk("pp_due_a", 64'(out_valid), 1);
        drive(1'b1, WRITE, 64'd0, 33'hB);
        out_ready = 1'b1;
        edge_step();
        drive(1'b0, NOP, '0, '0);
        out_ready = 1'b0;
        chk("pp_count", 64'(count), 1);
        chk("pp_head_b", 64'(out_address), 64'hB);
        chk("pp_op_b", 64'(out_op), 64'(WRITE));

        // out-of-order timestamps still issue in push order
        do_reset();
        drive(1'b1, READ, 64'd10, 33'h10);
        edge_step();
        chk("ord_err_first", 64'(err_order), 0);
        drive(1'b1, READ, 64'd7, 33'h7);
        edge_step();
        drive(1'b0, NOP, '0, '0);
        chk("ord_err_set", 64'(err_order), 1);
        chk("ord_count", 64'(count), 2);
        out_ready = 1'b1;
        begin
            logic [AW-1:0] exp_q [2];
            int idx = 0;
            exp_q[0] = 33'h10;
            exp_q[1] = 33'h7;
            for (int k = 0; k < 30; k++) begin
                if (out_valid && idx < 2) begin
                    chk($sformatf("ord_pop%0d", idx), 64'(out_address), 64'(exp_q[idx]));
                    idx++;
                end
                edge_step();
            end
            chk("ord_pop_total", 64'(idx), 2);
        end
        chk("ord_err_sticky", 64'(err_order), 1);

        // mid-operation half-period reset pulse
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, READ, 64'd0, 33'(33'h200 + i));
            edge_step();
        end
        drive(1'b0, NOP, '0, '0);
        chk("mid_count_before", 64'(count), 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_count", 64'(count), 0);
        chk("mid_rst_cycle", cycle, 0);
        chk("mid_rst_out_valid", 64'(out_valid), 0);
        chk("mid_rst_in_ready", 64'(in_ready), 1);
        chk("mid_rst_state", 64'(state), 64'(IDLE));
        chk("mid_rst_out_address", 64'(out_address), 0);
        #4;
        rst = 1'b0;
        out_ready = 1'b1;
        edge_step();
        chk("mid_cycle_one", cycle, 1);
        begin
            int stale = 0;
            for (int k = 0; k < 10; k++) begin
                if (out_valid || count != '0) stale++;
                edge_step();
            end
            chk("mid_no_stale", 64'(stale), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
